dm_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: M0 (CPU MEM stage) and M1 (debug/DMA port).

---
 rtl/dm_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dm_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dm_arbiter: two-requester arbiter and sequencer for the single-port DM.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module dm_arbiter #(
  parameter int          DM_WORDS   = 3072,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_op,
  input  logic        m0_ext,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_op,
  input  logic        m1_ext,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [1:0]  dm_op,
  output logic        dm_ext,
  input  logic [31:0] dm_rd
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [31:0] c_span = 32'(4 * DM_WORDS);

  state_t      r_state;
  logic        r_rr_last;
  logic        r_win;
  logic        r_we;
  logic        r_err;

  logic        w_win;
  logic        w_we;
  logic        w_ext;
  logic        w_err;
  logic        w_misalign;
  logic [1:0]  w_op_raw;
  logic [1:0]  w_op;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [32:0] w_off;

  // w_win: 0 selects M0, 1 selects M1
  always_comb begin
    if (m0_req && m1_req) w_win = FIXED_PRIO ? 1'b0 : ~r_rr_last;
    else                  w_win = m1_req;
  end

  assign w_we     = w_win ? m1_we    : m0_we;
  assign w_ext    = w_win ? m1_ext   : m0_ext;
  assign w_addr   = w_win ? m1_addr  : m0_addr;
  assign w_wdata  = w_win ? m1_wdata : m0_wdata;
  assign w_op_raw = w_win ? m1_op    : m0_op;
  assign w_op     = (w_op_raw == 2'b11) ? 2'b00 : w_op_raw;

  // Borrow out of the offset flags addresses below the DM window.
  assign w_off = {1'b0, w_addr} - {1'b0, BASE_ADDR};

  always_comb begin
    w_misalign = 1'b0;
    w_lane     = w_wdata;
    case (w_op)
      2'b01: begin
        w_misalign = w_addr[0];
        w_lane     = {16'h0000, w_wdata[15:0]} << {w_addr[1], 4'b0000};
      end
      2'b10: begin
        w_lane     = {24'h000000, w_wdata[7:0]} << {w_addr[1:0], 3'b000};
      end
      default: begin
        w_misalign = |w_addr[1:0];
      end
    endcase
  end

  assign w_err = w_misalign | w_off[32] | (w_off[31:0] >= c_span);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rr_last <= 1'b1;
      r_win     <= 1'b0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= 32'h0;
      m1_rdata  <= 32'h0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= 32'h0;
      dm_wdata  <= 32'h0;
      dm_op     <= 2'b00;
      dm_ext    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            r_state   <= ST_ACCESS;
            r_rr_last <= w_win;
            r_win     <= w_win;
            r_we      <= w_we;
            r_err     <= w_err;
            m0_gnt    <= ~w_win;
            m1_gnt    <= w_win;
            dm_we     <= w_we & ~w_err;
            dm_addr   <= w_addr;
            dm_wdata  <= w_lane;
            dm_op     <= w_op;
            dm_ext    <= w_ext;
          end
        end
        ST_ACCESS: begin
          // The DM write commits at this edge; load data is captured here too.
          r_state   <= ST_DONE;
          m0_gnt    <= 1'b0;
          m1_gnt    <= 1'b0;
          dm_we     <= 1'b0;
          dm_addr   <= 32'h0;
          dm_wdata  <= 32'h0;
          dm_op     <= 2'b00;
          dm_ext    <= 1'b0;
          m0_rvalid <= ~r_win;
          m1_rvalid <= r_win;
          m0_err    <= ~r_win & r_err;
          m1_err    <= r_win & r_err;
          m0_rdata  <= (~r_win & ~r_we & ~r_err) ? dm_rd : 32'h0;
          m1_rdata  <= (r_win & ~r_we & ~r_err) ? dm_rd : 32'h0;
        end
        default: begin
          r_state   <= ST_IDLE;
          m0_rvalid <= 1'b0;
          m1_rvalid <= 1'b0;
          m0_rdata  <= 32'h0;
          m1_rdata  <= 32'h0;
          m0_err    <= 1'b0;
          m1_err    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// tb_dm_arbiter: directed and randomized checks of dm_arbiter against a
// transaction-level model with a byte-array memory image.
module tb_dm_arbiter;

  localparam int DM_WORDS = 3072;
  localparam int NBYTES   = 4 * DM_WORDS;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_ext, m1_req, m1_we, m1_ext;
  logic [1:0]  m0_op, m1_op;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dm_we, dm_ext;
  logic [1:0]  dm_op;
  logic [31:0] dm_addr, dm_wdata, dm_rd;

  logic        fp_m0_gnt, fp_m0_rvalid, fp_m0_err, fp_m1_gnt, fp_m1_rvalid, fp_m1_err;
  logic [31:0] fp_m0_rdata, fp_m1_rdata;
  logic        fp_dm_we, fp_dm_ext;
  logic [1:0]  fp_dm_op;
  logic [31:0] fp_dm_addr, fp_dm_wdata;

  always #5 clk = ~clk;

  dm_arbiter #(.DM_WORDS(DM_WORDS), .BASE_ADDR(32'h0), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_op(m0_op), .m0_ext(m0_ext),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_op(m1_op), .m1_ext(m1_ext),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_op(dm_op),
    .dm_ext(dm_ext), .dm_rd(dm_rd)
  );

  // Fixed-priority instance: both requesters permanently request a word load.
  dm_arbiter #(.DM_WORDS(DM_WORDS), .BASE_ADDR(32'h0), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_req(1'b1), .m0_we(1'b0), .m0_op(2'b00), .m0_ext(1'b0),
    .m0_addr(32'h10), .m0_wdata(32'h0), .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid),
    .m0_rdata(fp_m0_rdata), .m0_err(fp_m0_err),
    .m1_req(1'b1), .m1_we(1'b0), .m1_op(2'b00), .m1_ext(1'b0),
    .m1_addr(32'h20), .m1_wdata(32'h0), .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid),
    .m1_rdata(fp_m1_rdata), .m1_err(fp_m1_err),
    .dm_we(fp_dm_we), .dm_addr(fp_dm_addr), .dm_wdata(fp_dm_wdata), .dm_op(fp_dm_op),
    .dm_ext(fp_dm_ext), .dm_rd(32'h0)
  );

  // Stand-in data memory: word storage, combinational extract/extend on read.
  logic [31:0] dm_mem [DM_WORDS];
  logic [31:0] dm_word, dm_mask, dm_sh;
  logic        dm_clr;
  int          dm_idx;

  always_comb begin
    dm_idx  = int'(dm_addr[31:2]);
    dm_word = (dm_idx < DM_WORDS) ? dm_mem[dm_idx] : 32'h0;
    dm_mask = 32'hFFFF_FFFF;
    dm_sh   = dm_word;
    dm_rd   = dm_word;
    case (dm_op)
      2'b01: begin
        dm_mask = 32'h0000_FFFF << {dm_addr[1], 4'b0000};
        dm_sh   = dm_word >> {dm_addr[1], 4'b0000};
        dm_rd   = dm_ext ? {{16{dm_sh[15]}}, dm_sh[15:0]} : {16'h0, dm_sh[15:0]};
      end
      2'b10: begin
        dm_mask = 32'h0000_00FF << {dm_addr[1:0], 3'b000};
        dm_sh   = dm_word >> {dm_addr[1:0], 3'b000};
        dm_rd   = dm_ext ? {{24{dm_sh[7]}}, dm_sh[7:0]} : {24'h0, dm_sh[7:0]};
      end
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (dm_clr) begin
      for (int i = 0; i < DM_WORDS; i++) dm_mem[i] <= 32'h0;
    end else if (dm_we && dm_idx < DM_WORDS) begin
      dm_mem[dm_idx] <= (dm_mem[dm_idx] & ~dm_mask) | (dm_wdata & dm_mask);
    end
  end

  // Reference model state.
  logic [7:0]  ref_mem [NBYTES];
  int          cyc, free_at, acc_cyc, fp_cnt;
  bit          last_win;
  bit          a_who, a_we, a_ext, a_err;
  logic [1:0]  a_op;
  logic [31:0] a_addr, a_wdata, a_lane, a_rdata;
  int          n_chk, n_fail;

  int          x_lat;
  logic        x_dm_we, x_err;
  logic [1:0]  x_dm_op;
  logic [31:0] x_dm_wdata, x_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] op);
    return (op == 2'b01) ? 2 : (op == 2'b10) ? 1 : 4;
  endfunction

  function automatic bit is_err(input logic [1:0] op, input logic [31:0] addr);
    return (addr >= 32'(NBYTES)) || (op == 2'b01 && addr[0]) ||
           (nbytes(op) == 4 && addr[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] lane(input logic [31:0] wd, input logic [1:0] op,
                                       input logic [31:0] addr);
    if (op == 2'b01) return (wd & 32'hFFFF) << (16 * int'(addr[1]));
    if (op == 2'b10) return (wd & 32'hFF) << (8 * int'(addr[1:0]));
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] op,
                                           input logic ext);
    int n;
    logic [31:0] v;
    n = nbytes(op);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
    if (ext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // Called once per rising edge with the inputs as sampled at that edge.
  task automatic model_edge();
    bit who;
    cyc++;
    if (reset) begin
      acc_cyc = -10; free_at = 0; last_win = 1'b1;
      return;
    end
    if (cyc == acc_cyc + 1 && a_we && !a_err)
      for (int i = 0; i < nbytes(a_op); i++) ref_mem[int'(a_addr) + i] = a_wdata[8*i +: 8];
    if (cyc >= free_at && (m0_req || m1_req)) begin
      who      = (m0_req && m1_req) ? ~last_win : m1_req;
      last_win = who;
      a_who    = who;
      a_we     = who ? m1_we    : m0_we;
      a_op     = who ? m1_op    : m0_op;
      a_ext    = who ? m1_ext   : m0_ext;
      a_addr   = who ? m1_addr  : m0_addr;
      a_wdata  = who ? m1_wdata : m0_wdata;
      a_err    = is_err(a_op, a_addr);
      a_lane   = lane(a_wdata, a_op, a_addr);
      a_rdata  = (!a_we && !a_err) ? ref_load(a_addr, a_op, a_ext) : 32'h0;
      acc_cyc  = cyc;
      free_at  = cyc + 3;
    end
  endtask

  task automatic compare();
    bit g, r;
    g = (cyc == acc_cyc);
    r = (cyc == acc_cyc + 1);
    chk("m0_gnt",    32'(m0_gnt),    32'(g && !a_who));
    chk("m1_gnt",    32'(m1_gnt),    32'(g && a_who));
    chk("dm_we",     32'(dm_we),     32'(g && a_we && !a_err));
    chk("dm_addr",   dm_addr,        g ? a_addr : 32'h0);
    chk("dm_wdata",  dm_wdata,       g ? a_lane : 32'h0);
    chk("dm_op",     32'(dm_op),     g ? 32'(a_op) : 32'h0);
    chk("dm_ext",    32'(dm_ext),    32'(g && a_ext));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(r && !a_who));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(r && a_who));
    chk("m0_rdata",  m0_rdata,       (r && !a_who) ? a_rdata : 32'h0);
    chk("m1_rdata",  m1_rdata,       (r && a_who) ? a_rdata : 32'h0);
    chk("m0_err",    32'(m0_err),    32'(r && !a_who && a_err));
    chk("m1_err",    32'(m1_err),    32'(r && a_who && a_err));
    chk("fp_m1_activity", 32'(fp_m1_gnt | fp_m1_rvalid | fp_m1_err | (|fp_m1_rdata)), 32'h0);
    chk("fp_m0_data",     32'(fp_m0_err | (|fp_m0_rdata) | fp_dm_we | (|fp_dm_wdata)), 32'h0);
    chk("fp_dm_fields",   32'((fp_dm_addr != 32'h0 && fp_dm_addr != 32'h10) | (|fp_dm_op) | fp_dm_ext), 32'h0);
    if (fp_m0_gnt) fp_cnt++;
    if (fp_m0_rvalid) fp_cnt += 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  // Called at a falling edge; checks outputs clear without waiting for a clock.
  task automatic do_reset();
    reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    acc_cyc = -10; free_at = 0; last_win = 1'b1;
    #1 compare();
    step();
    reset = 1'b0;
  endtask

  task automatic xact(input bit who, input logic we, input logic [1:0] op, input logic ext,
                      input logic [31:0] addr, input logic [31:0] wdata);
    bit got;
    got = 1'b0; x_lat = -1; x_dm_we = 1'b0; x_dm_op = 2'b00;
    x_dm_wdata = 32'h0; x_rdata = 32'h0; x_err = 1'b0;
    if (who) begin
      m1_we = we; m1_op = op; m1_ext = ext; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
    end else begin
      m0_we = we; m0_op = op; m0_ext = ext; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      if (!got && acc_cyc == cyc && a_who == who) begin
        got = 1'b1; x_dm_we = dm_we; x_dm_wdata = dm_wdata; x_dm_op = dm_op;
        if (who) m1_req = 1'b0; else m0_req = 1'b0;
      end else if (got && cyc == acc_cyc + 1) begin
        x_lat   = k;
        x_rdata = who ? m1_rdata : m0_rdata;
        x_err   = who ? m1_err : m0_err;
        break;
      end
    end
    chk("xact_completed", 32'(x_lat > 0), 32'h1);
    step();
  endtask

  task automatic new_txn(output logic we, output logic [1:0] op, output logic ext,
                         output logic [31:0] addr, output logic [31:0] wdata);
    int r;
    we    = 1'($urandom_range(0, 1));
    op    = 2'($urandom_range(0, 2));
    ext   = 1'($urandom_range(0, 1));
    wdata = $urandom;
    r     = $urandom_range(0, 15);
    if (r < 12) begin
      addr = 32'($urandom_range(0, 63));
      if (op == 2'b00) addr[1:0] = 2'b00;
      else if (op == 2'b01) addr[0] = 1'b0;
    end else if (r < 14) begin
      addr = 32'($urandom_range(0, 63));
    end else if (r == 14) begin
      addr = ($urandom_range(0, 1) == 1) ? 32'h3000 + 32'($urandom_range(0, 15)) : 32'hFFFF_FFFC;
    end else begin
      addr = ($urandom_range(0, 1) == 1) ? 32'h2FFC : 32'h2FFF;
    end
  endtask

  initial begin
    int idle_act;
    int gseq[$];
    int exp_alt[4];
    exp_alt = '{0, 1, 0, 1};
    n_chk = 0; n_fail = 0; cyc = 0; acc_cyc = -10; free_at = 0; last_win = 1'b1; fp_cnt = 0;
    reset = 1'b1; dm_clr = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_op = 2'b00; m0_ext = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_op = 2'b00; m1_ext = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    step();
    dm_clr = 1'b0;
    reset  = 1'b0;

    // Word store then load on M0.
    xact(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h1234_5678);
    chk("st_word_latency", 32'(x_lat), 32'd2);
    chk("st_word_dm_we", 32'(x_dm_we), 32'h1);
    xact(1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    chk("ld_word_rdata", x_rdata, 32'h1234_5678);
    chk("ld_word_err", 32'(x_err), 32'h0);

    // Byte store and sign-extended byte load on M1.
    xact(1'b1, 1'b1, 2'b10, 1'b0, 32'h23, 32'h0000_00AB);
    chk("st_byte_dm_wdata", x_dm_wdata, 32'hAB00_0000);
    chk("st_byte_dm_op", 32'(x_dm_op), 32'h2);
    xact(1'b1, 1'b0, 2'b10, 1'b1, 32'h23, 32'h0);
    chk("ld_byte_ext_rdata", x_rdata, 32'hFFFF_FFAB);

    // Upper half-word lane, then misaligned and out-of-range accesses.
    xact(1'b0, 1'b1, 2'b00, 1'b0, 32'h00, 32'hBEEF_1234);
    xact(1'b0, 1'b0, 2'b01, 1'b0, 32'h02, 32'h0);
    chk("ld_half_rdata", x_rdata, 32'h0000_BEEF);
    chk("ld_half_err", 32'(x_err), 32'h0);
    xact(1'b0, 1'b0, 2'b00, 1'b0, 32'h06, 32'h0);
    chk("ld_misalign_err", 32'(x_err), 32'h1);
    chk("ld_misalign_rdata", x_rdata, 32'h0);
    xact(1'b0, 1'b1, 2'b00, 1'b0, 32'h3000, 32'hCAFE_F00D);
    chk("st_range_err", 32'(x_err), 32'h1);
    chk("st_range_dm_we", 32'(x_dm_we), 32'h0);

    // Reset while a store is in its access cycle.
    m0_we = 1'b1; m0_op = 2'b00; m0_ext = 1'b0; m0_addr = 32'h40; m0_wdata = 32'hDEAD_BEEF;
    m0_req = 1'b1;
    step();
    chk("mid_access_dm_we", 32'(dm_we), 32'h1);
    do_reset();
    chk("post_reset_rvalid", 32'(m0_rvalid), 32'h0);
    xact(1'b0, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0);
    chk("post_reset_latency", 32'(x_lat), 32'd2);
    chk("post_reset_rdata", x_rdata, 32'h0);

    // Idle interval.
    idle_act = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (m0_gnt | m1_gnt | m0_rvalid | m1_rvalid | dm_we) idle_act++;
    end
    chk("idle_activity", 32'(idle_act), 32'h0);

    // Both requesters held: grants alternate starting with M0.
    do_reset();
    m0_we = 1'b0; m0_op = 2'b00; m0_addr = 32'h10; m1_we = 1'b0; m1_op = 2'b00; m1_addr = 32'h10;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (m0_gnt) gseq.push_back(0);
      if (m1_gnt) gseq.push_back(1);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("alt_grant_count", 32'(gseq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < gseq.size()) chk("alt_grant_order", 32'(gseq[i]), 32'(exp_alt[i]));
    step();

    // Randomized traffic from both requesters.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if (m0_req && acc_cyc == cyc && !a_who) m0_req = 1'b0;
      if (m1_req && acc_cyc == cyc && a_who)  m1_req = 1'b0;
      if (!m0_req) begin
        new_txn(m0_we, m0_op, m0_ext, m0_addr, m0_wdata);
        m0_req = ($urandom_range(0, 2) == 0);
      end
      if (!m1_req) begin
        new_txn(m1_we, m1_op, m1_ext, m1_addr, m1_wdata);
        m1_req = ($urandom_range(0, 2) == 0);
      end
      step();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("fp_m0_granted", 32'(fp_cnt > 0), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
